// File: rtl/llc_plru_engine.sv
// Purpose: per-set 16-way tree pseudo-LRU store and victim selector for the LLC.
// Latency: response strobe 3 cycles after the handshake edge (READ, UPDATE, resp); one request per 3 cycles.
// Backpressure: req_ready low during the post-reset sweep and while a request is in flight; requester holds req_* stable.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_op                          0 = ACCESS (mark req_way MRU), 1 = VICTIM (select way, mark it MRU)
//   req_index, req_way              set index, accessed way (ACCESS only)
//   req_invalid_mask                bit w = 1 -> way w invalid (VICTIM only)
//   resp_valid, resp_way, resp_err  one-cycle response strobe, selected/echoed way, index out of range
//   init_done                       post-reset clear sweep finished
module llc_plru_engine #(
    parameter int SETS          = 15625,
    parameter int INDEX         = 14,
    parameter int ASSOCIATIVITY = 16,
    parameter int PSEUDO_LRU    = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_op,
    input  logic [INDEX-1:0]                 req_index,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] req_way,
    input  logic [ASSOCIATIVITY-1:0]         req_invalid_mask,
    output logic                             resp_valid,
    output logic [$clog2(ASSOCIATIVITY)-1:0] resp_way,
    output logic                             resp_err,
    output logic                             init_done
);

    localparam int WAY_W  = $clog2(ASSOCIATIVITY);
    localparam int ADDR_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int NODE_W = (PSEUDO_LRU > 1) ? $clog2(PSEUDO_LRU) : 1;

    // One extra bit so an index equal to 2**INDEX never aliases into range.
    localparam logic [INDEX:0]    SETS_CMP = (INDEX + 1)'(SETS);
    localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_UPDATE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]        sweep_ptr;
    logic                     op_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [WAY_W-1:0]         way_q;
    logic [ASSOCIATIVITY-1:0] mask_q;
    logic                     err_q;
    logic                     resp_vld_q;

    logic [PSEUDO_LRU-1:0]    tree_mem [SETS];
    logic [PSEUDO_LRU-1:0]    rd_dat;

    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [PSEUDO_LRU-1:0]    mem_wdat;
    logic [WAY_W-1:0]         sel_way;
    logic [PSEUDO_LRU-1:0]    tree_nxt;
    logic                     idx_oob;

    // ------------------------------------------------------------------
    // Tree helpers: node n has children 2n+1 (left) and 2n+2 (right).
    // ------------------------------------------------------------------
    function automatic logic [NODE_W-1:0] child(input logic [NODE_W-1:0] n, input logic b);
        logic [NODE_W:0] c;
        c = {n, 1'b0} + {{NODE_W{1'b0}}, 1'b1} + {{NODE_W{1'b0}}, b};
        // Past the last internal level the value is discarded, so truncation is harmless.
        return c[NODE_W-1:0];
    endfunction

    function automatic logic [WAY_W-1:0] plru_walk(input logic [PSEUDO_LRU-1:0] t);
        logic [NODE_W-1:0] node;
        logic [WAY_W-1:0]  w;
        logic              b;
        node = '0;
        w    = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b                 = t[node];
            w[WAY_W-1-lvl]    = b;
            node              = child(node, b);
        end
        return w;
    endfunction

    // Every node on the way's path is flipped to point away from it.
    function automatic logic [PSEUDO_LRU-1:0] mru_update(input logic [PSEUDO_LRU-1:0] t,
                                                         input logic [WAY_W-1:0]      w);
        logic [NODE_W-1:0]     node;
        logic [PSEUDO_LRU-1:0] r;
        logic                  b;
        node = '0;
        r    = t;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b       = w[WAY_W-1-lvl];
            r[node] = ~b;
            node    = child(node, b);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] lowest_invalid(input logic [ASSOCIATIVITY-1:0] m);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (m[i]) w = WAY_W'(i);
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:   if (sweep_ptr == LAST_SET) state_nxt = ST_IDLE;
            ST_IDLE:   if (req_valid)             state_nxt = ST_READ;
            ST_READ:   state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_INIT;
        endcase
    end

    assign req_ready  = (state == ST_IDLE) && !rst;
    assign resp_valid = resp_vld_q && !rst;
    assign idx_oob    = ({1'b0, req_index} >= SETS_CMP);

    // ------------------------------------------------------------------
    // Way selection and next tree, evaluated during UPDATE from rd_dat.
    // ------------------------------------------------------------------
    always_comb begin
        sel_way  = way_q;
        tree_nxt = rd_dat;
        if (op_q) begin
            if (|mask_q) sel_way = lowest_invalid(mask_q);
            else         sel_way = plru_walk(rd_dat);
        end
        tree_nxt = mru_update(rd_dat, sel_way);
    end

    // ------------------------------------------------------------------
    // Request latch, sweep pointer and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_ptr  <= '0;
            init_done  <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_way   <= '0;
            resp_err   <= 1'b0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            way_q      <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            resp_vld_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    sweep_ptr <= sweep_ptr + 1'b1;
                    if (sweep_ptr == LAST_SET) init_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        addr_q <= req_index[ADDR_W-1:0];
                        way_q  <= req_way;
                        mask_q <= req_invalid_mask;
                        err_q  <= idx_oob;
                    end
                end
                ST_UPDATE: begin
                    resp_vld_q <= 1'b1;
                    resp_err   <= err_q;
                    resp_way   <= err_q ? '0 : sel_way;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tree RAM: one write port (sweep or write-back), one registered read.
    // An out-of-range request never touches the array.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdat  = tree_nxt;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_ptr;
                mem_wdat  = '0;
            end else if (state == ST_UPDATE && !err_q) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) tree_mem[mem_waddr] <= mem_wdat;
        if (state == ST_READ && !err_q) rd_dat <= tree_mem[addr_q];
    end

endmodule

// File: tb/tb_llc_plru_engine.sv
// Purpose: self-checking bench for llc_plru_engine with a 16-set instance and a reference tree model.
// Latency: expects each response 3 cycles after its handshake, and a 16-cycle clear sweep after reset.
// Backpressure: driver holds req_* while req_ready is low, accepting back-to-back in the response cycle.
module tb_llc_plru_engine;

    localparam int NSETS = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [4:0]  req_index;
    logic [3:0]  req_way;
    logic [15:0] req_invalid_mask;
    logic        resp_valid;
    logic [3:0]  resp_way;
    logic        resp_err;
    logic        init_done;

    llc_plru_engine #(
        .SETS          (NSETS),
        .INDEX         (5),
        .ASSOCIATIVITY (16),
        .PSEUDO_LRU    (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_index        (req_index),
        .req_way          (req_way),
        .req_invalid_mask (req_invalid_mask),
        .resp_valid       (resp_valid),
        .resp_way         (resp_way),
        .resp_err         (resp_err),
        .init_done        (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       err;
        logic [3:0] way;
        int         hs;
    } exp_t;

    exp_t        exp_q[$];
    logic [14:0] model [NSETS];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: walk node indices down to a leaf, way = leaf - 15.
    function automatic int mdl_victim(input logic [14:0] t);
        int n = 0;
        while (n < 15) n = t[n[3:0]] ? (2 * n + 2) : (2 * n + 1);
        return n - 15;
    endfunction

    // Climb from the leaf; a parent reached from its left child gets 1, from its right child 0.
    function automatic logic [14:0] mdl_mru(input logic [14:0] t, input int w);
        int n = w + 15;
        int p;
        while (n > 0) begin
            p = (n - 1) / 2;
            t[p[3:0]] = (n == 2 * p + 1);
            n = p;
        end
        return t;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) model[s] = '0;
    endtask

    // Drive one request; returns at the negedge after its handshake edge.
    // exp_way >= 0 forces a fixed expected way instead of the model's choice.
    task automatic do_req(input logic op, input int idx, input int way, input logic [15:0] mask,
                          input int exp_way, output int hs, output logic rv_at_accept);
        int   n = 0;
        int   w;
        exp_t e;
        req_op           = op;
        req_index        = 5'(idx);
        req_way          = 4'(way);
        req_invalid_mask = mask;
        req_valid        = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        hs           = -1;
        rv_at_accept = resp_valid;
        if (!req_ready) begin
            check_val("handshake_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (idx >= NSETS) begin
            e.err = 1'b1;
            e.way = 4'd0;
        end else begin
            if (!op) w = way;
            else if (mask != 16'd0) begin
                w = -1;
                for (int i = 0; i < 16; i++) if (mask[i] && w < 0) w = i;
            end else w = mdl_victim(model[idx]);
            model[idx] = mdl_mru(model[idx], w);
            e.err = 1'b0;
            e.way = (exp_way >= 0) ? 4'(exp_way) : 4'(w);
        end
        @(posedge clk);
        #1;
        hs   = cyc;
        e.hs = hs;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic init_sweep_check();
        int n = 0;
        rst = 1'b0;
        #1;
        check_val("init_done_during_sweep", init_done, 0);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_val("init_sweep_cycles", n, NSETS);
        check_val("init_done_after_sweep", init_done, 1);
    endtask

    // Response scoreboard; also polices resp_valid while reset is asserted.
    always @(negedge clk) begin
        if (rst) begin
            check_val("resp_valid_in_reset", resp_valid, 0);
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("resp_way", resp_way, e.way);
                check_val("resp_err", resp_err, e.err);
                check_val("resp_latency", cyc - e.hs + 1, 3);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs1, hs2, n;
        logic rv;
        rst              = 1'b1;
        req_valid        = 1'b0;
        req_op           = 1'b0;
        req_index        = '0;
        req_way          = '0;
        req_invalid_mask = '0;
        model_clear();
        repeat (4) @(negedge clk);

        // Reset state
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_resp_way", resp_way, 0);
        check_val("rst_resp_err", resp_err, 0);
        check_val("rst_init_done", init_done, 0);
        init_sweep_check();

        // First request on a cleared set
        do_req(1'b1, 3, 0, 16'h0000, 0, hs1, rv);

        // Out-of-range indices, including the first one past the end
        do_req(1'b1, 20, 0, 16'h0000, -1, hs1, rv);
        do_req(1'b0, 16, 7, 16'h0000, -1, hs1, rv);

        // PLRU sequence on set 5, set 6 untouched
        do_req(1'b0, 5, 0, 16'h0000, 0, hs1, rv);
        do_req(1'b1, 5, 0, 16'h0000, 8, hs1, rv);
        do_req(1'b1, 5, 0, 16'h0000, 4, hs1, rv);
        do_req(1'b1, 6, 0, 16'h0000, 0, hs1, rv);

        // Invalid-way priority, then the tree result; mask is ignored for ACCESS
        do_req(1'b1, 2, 0, 16'h0C00, 10, hs1, rv);
        do_req(1'b1, 2, 0, 16'h0000, -1, hs1, rv);
        do_req(1'b0, 2, 5, 16'hFFFF, 5, hs1, rv);
        do_req(1'b1, 2, 0, 16'h8000, 15, hs1, rv);

        // Back-to-back on the same set: accepted in the response cycle
        do_req(1'b0, 1, 15, 16'h0000, 15, hs1, rv);
        do_req(1'b1, 1, 0, 16'h0000, 0, hs2, rv);
        check_val("b2b_handshake_gap", hs2 - hs1, 3);
        check_val("b2b_accept_in_resp_cycle", rv, 1);

        // Mixed traffic against the model, occasionally out of range
        for (int i = 0; i < 40; i++) begin
            logic [15:0] m;
            m = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
            do_req(1'($urandom_range(0, 1)), $urandom_range(0, 17), $urandom_range(0, 15), m, -1, hs1, rv);
        end

        // Reset during READ: response dropped, sweep restarts, trees cleared
        do_req(1'b0, 7, 0, 16'h0000, -1, hs1, rv);
        do_req(1'b1, 9, 0, 16'h0000, -1, hs1, rv);
        rst = 1'b1;
        exp_q.delete();
        model_clear();
        repeat (3) @(negedge clk);
        check_val("midreq_rst_req_ready", req_ready, 0);
        check_val("midreq_rst_init_done", init_done, 0);
        init_sweep_check();
        for (int s = 0; s < NSETS; s++) do_req(1'b1, s, 0, 16'h0000, 0, hs1, rv);

        // Drain outstanding responses
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("pending_responses", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
